cva6_wt_store_buf: RTL and testbench

- Small in-order store buffer between the load/store unit's store path and the write-through data-cache memory port, sized by the core configuration (write-buffer depth 2, max outstanding stores 7, memory TID width 2).
- Accepts byte-enabled word stores, optionally merges same-word cacheable stores, and issues them in order with a req/gnt handshake.
- Tracks outstanding memory writes until acknowledged; exposes a load-hazard check and an empty flag for fences.

---
 rtl/cva6_wt_store_buf.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cva6_wt_store_buf.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_wt_store_buf.sv
// ---------------------------------------------------------------------------
// cva6_wt_store_buf
//
// In-order store buffer between the LSU store path and the write-through
// data-cache memory port. Byte-enabled word stores are queued in a small
// circular FIFO and issued oldest-first over a req/gnt handshake. Granted
// writes are counted as outstanding until acknowledged.
//
// Optional feature (macro STORE_BUF_MERGE_EN):
//   defined   - a cacheable store to the same word as the youngest cacheable
//               entry is merged into it, provided that entry is not the one
//               currently presented on the memory port.
//   undefined - every accepted store allocates its own entry.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   st_valid_i/ready_o  store handshake; ready depends on registered state only
//   st_addr_i           store byte address (offset bits ignored)
//   st_data_i, st_be_i  lane-aligned store data and non-zero byte enables
//   st_nc_i             non-cacheable store, never merged
//   mem_req_o/gnt_i     write request handshake towards memory
//   mem_addr_o          word-aligned address of the head entry
//   mem_data_o/be_o     head entry data and byte enables
//   mem_tid_o           transaction ID, advances on every grant
//   mem_ack_i           write acknowledge, retires one outstanding write
//   rd_addr_i/rd_hit_o  load hazard check against all queued entries
//   empty_o             no queued entries and no outstanding writes
//   outstanding_o       granted-but-unacknowledged write count
// ---------------------------------------------------------------------------
module cva6_wt_store_buf #(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned MAX_OUTSTANDING = 7,
    parameter int unsigned TID_W           = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic [ADDR_W-1:0]   st_addr_i,
    input  logic [DATA_W-1:0]   st_data_i,
    input  logic [DATA_W/8-1:0] st_be_i,
    input  logic                st_nc_i,

    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [TID_W-1:0]    mem_tid_o,
    input  logic                mem_ack_i,

    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic                rd_hit_o,
    output logic                empty_o,
    output logic [2:0]          outstanding_o
);

    localparam int unsigned BeW    = DATA_W / 8;
    localparam int unsigned OffW   = $clog2(BeW);
    localparam int unsigned WaddrW = ADDR_W - OffW;
    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned OutW   = 3;

    // Entry storage
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  nc_q, nc_d;
    logic [WaddrW-1:0] addr_q [DEPTH];
    logic [WaddrW-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [BeW-1:0]    be_q   [DEPTH];
    logic [BeW-1:0]    be_d   [DEPTH];

    // Queue bookkeeping
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [OutW-1:0]   outstanding_q, outstanding_d;
    logic [TID_W-1:0]  tid_q, tid_d;

    logic [WaddrW-1:0] st_word;
    logic [WaddrW-1:0] rd_word;
    logic [PtrW-1:0]   young_idx;
    logic              head_valid;
    logic              full;
    logic              merge_ok;
    logic              accept;
    logic              do_merge;
    logic              do_alloc;
    logic              pop;
    logic              ack_ok;
    logic              unused_offset;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign st_word = st_addr_i[ADDR_W-1:OffW];
    assign rd_word = rd_addr_i[ADDR_W-1:OffW];

    // Byte offsets never take part in any word compare.
    assign unused_offset = ^{st_addr_i[OffW-1:0], rd_addr_i[OffW-1:0]};

    // The youngest entry sits just behind the tail pointer.
    assign young_idx  = (tail_q == '0) ? PtrW'(DEPTH - 1) : tail_q - PtrW'(1);
    assign head_valid = valid_q[head_q];
    assign full       = (count_q == CntW'(DEPTH));

    assign mem_req_o  = head_valid && (outstanding_q < OutW'(MAX_OUTSTANDING));

`ifdef STORE_BUF_MERGE_EN
    // Merging into the presented head would change data mid-handshake.
    assign merge_ok = valid_q[young_idx] && !nc_q[young_idx] && !st_nc_i &&
                      (addr_q[young_idx] == st_word) &&
                      !(mem_req_o && (young_idx == head_q));
`else
    logic unused_merge;
    assign merge_ok     = 1'b0;
    assign unused_merge = ^{nc_q, young_idx};
`endif

    // A same-cycle grant does not open a slot: ready uses registered state.
    assign st_ready_o = !full || merge_ok;
    assign accept     = st_valid_i && st_ready_o;
    assign do_merge   = accept && merge_ok;
    assign do_alloc   = accept && !merge_ok;
    assign pop        = mem_req_o && mem_gnt_i;
    assign ack_ok     = mem_ack_i && (outstanding_q != '0);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d       = valid_q;
        nc_d          = nc_q;
        addr_d        = addr_q;
        data_d        = data_q;
        be_d          = be_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        tid_d         = tid_q;

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
            tid_d           = tid_q + TID_W'(1);
        end

        // Merge and pop never target the same entry (see merge_ok).
        if (do_merge) begin
            for (int unsigned b = 0; b < BeW; b++) begin
                if (st_be_i[b]) begin
                    data_d[young_idx][8*b +: 8] = st_data_i[8*b +: 8];
                end
            end
            be_d[young_idx] = be_q[young_idx] | st_be_i;
        end

        if (do_alloc) begin
            valid_d[tail_q] = 1'b1;
            nc_d[tail_q]    = st_nc_i;
            addr_d[tail_q]  = st_word;
            data_d[tail_q]  = st_data_i;
            be_d[tail_q]    = st_be_i;
            tail_d          = ptr_inc(tail_q);
        end

        unique case ({do_alloc, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        unique case ({pop, ack_ok})
            2'b10:   outstanding_d = outstanding_q + OutW'(1);
            2'b01:   outstanding_d = outstanding_q - OutW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q       <= '0;
            nc_q          <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            tid_q         <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            nc_q          <= nc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            tid_q         <= tid_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
                be_q[i]   <= be_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Payload is zeroed when nothing is queued so an idle port stays quiet.
    assign mem_addr_o    = head_valid ? {addr_q[head_q], {OffW{1'b0}}} : '0;
    assign mem_data_o    = head_valid ? data_q[head_q] : '0;
    assign mem_be_o      = head_valid ? be_q[head_q] : '0;
    assign mem_tid_o     = tid_q;
    assign empty_o       = (count_q == '0) && (outstanding_q == '0);
    assign outstanding_o = outstanding_q;

    // Granted writes have left the buffer and are not hazard-checked.
    always_comb begin
        rd_hit_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == rd_word)) begin
                rd_hit_o = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Assertions
    // -----------------------------------------------------------------------
    ack_without_outstanding_a: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(mem_ack_i && (outstanding_q == '0))
    );

    st_be_nonzero_a: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        st_valid_i |-> (st_be_i != '0)
    );

    req_held_stable_a: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (mem_req_o && !mem_gnt_i) |=>
            (mem_req_o && $stable(mem_addr_o) && $stable(mem_data_o) &&
             $stable(mem_be_o) && $stable(mem_tid_o))
    );

endmodule

// File: tb/tb_cva6_wt_store_buf.sv
// ---------------------------------------------------------------------------
// tb_cva6_wt_store_buf
//
// Self-checking bench. A queue-based reference model of the buffered stores
// predicts handshake/status outputs every cycle and holds the expected write
// sequence; a separate monitor pops and compares on every memory grant.
// Inputs change 2 time units after the rising edge; the model samples on the
// falling edge and the monitor 1 unit later.
// ---------------------------------------------------------------------------
module tb_cva6_wt_store_buf;

    localparam int unsigned Depth  = 2;
    localparam int unsigned MaxOut = 7;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        st_valid_i;
    logic        st_ready_o;
    logic [31:0] st_addr_i;
    logic [63:0] st_data_i;
    logic [7:0]  st_be_i;
    logic        st_nc_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_data_o;
    logic [7:0]  mem_be_o;
    logic [1:0]  mem_tid_o;
    logic        mem_ack_i;
    logic [31:0] rd_addr_i;
    logic        rd_hit_o;
    logic        empty_o;
    logic [2:0]  outstanding_o;

    cva6_wt_store_buf #(
        .DEPTH          (Depth),
        .ADDR_W         (32),
        .DATA_W         (64),
        .MAX_OUTSTANDING(MaxOut),
        .TID_W          (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .st_valid_i   (st_valid_i),
        .st_ready_o   (st_ready_o),
        .st_addr_i    (st_addr_i),
        .st_data_i    (st_data_i),
        .st_be_i      (st_be_i),
        .st_nc_i      (st_nc_i),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_be_o     (mem_be_o),
        .mem_tid_o    (mem_tid_o),
        .mem_ack_i    (mem_ack_i),
        .rd_addr_i    (rd_addr_i),
        .rd_hit_o     (rd_hit_o),
        .empty_o      (empty_o),
        .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        logic        nc;
    } entry_t;

    entry_t q[$];          // stores held in the buffer, oldest first
    int     m_out    = 0;  // expected outstanding writes
    int     m_tid    = 0;  // expected TID of the next grant
    int     ack_mode = 0;  // 0 none, 1 whenever legal, 2 random when legal
    int     checks   = 0;
    int     errors   = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a & 32'hFFFF_FFF8;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: per-cycle predictions, store acceptance, counters
    // -----------------------------------------------------------------------
    always @(negedge clk_i) begin : model
        bit     exp_req;
        bit     exp_ready;
        bit     exp_hit;
        bit     do_merge;
        int     old_out;
        entry_t e;
        if (!rst_ni) begin
            q.delete();
            m_out = 0;
            m_tid = 0;
            check("rst_req", {63'd0, mem_req_o}, 64'd0);
            check("rst_ready", {63'd0, st_ready_o}, 64'd1);
            check("rst_empty", {63'd0, empty_o}, 64'd1);
            check("rst_outstanding", {61'd0, outstanding_o}, 64'd0);
            check("rst_addr", {32'd0, mem_addr_o}, 64'd0);
            check("rst_tid", {62'd0, mem_tid_o}, 64'd0);
            check("rst_hit", {63'd0, rd_hit_o}, 64'd0);
        end else begin
            exp_req  = (q.size() > 0) && (m_out < MaxOut);
            do_merge = 1'b0;
`ifdef STORE_BUF_MERGE_EN
            if (q.size() > 0) begin
                e = q[q.size() - 1];
                do_merge = !e.nc && !st_nc_i && (e.addr == word_of(st_addr_i)) &&
                           !(exp_req && (q.size() == 1));
            end
`endif
            exp_ready = (q.size() < Depth) || do_merge;
            exp_hit   = 1'b0;
            foreach (q[i]) begin
                if (q[i].addr == word_of(rd_addr_i)) exp_hit = 1'b1;
            end

            check("ready", {63'd0, st_ready_o}, {63'd0, exp_ready});
            check("req", {63'd0, mem_req_o}, {63'd0, exp_req});
            check("empty", {63'd0, empty_o}, {63'd0, (q.size() == 0) && (m_out == 0)});
            check("outstanding", {61'd0, outstanding_o}, 64'(m_out));
            check("rd_hit", {63'd0, rd_hit_o}, {63'd0, exp_hit});

            if (st_valid_i && exp_ready) begin
                if (do_merge) begin
                    e = q.pop_back();
                    for (int b = 0; b < 8; b++) begin
                        if (st_be_i[b]) e.data[8*b +: 8] = st_data_i[8*b +: 8];
                    end
                    e.be = e.be | st_be_i;
                    q.push_back(e);
                end else begin
                    e.addr = word_of(st_addr_i);
                    e.data = st_data_i;
                    e.be   = st_be_i;
                    e.nc   = st_nc_i;
                    q.push_back(e);
                end
            end

            old_out = m_out;
            if (mem_ack_i && (old_out > 0)) m_out--;
            if (exp_req && mem_gnt_i) m_out++;
        end
    end

    // -----------------------------------------------------------------------
    // Monitor: every grant retires the oldest expected write
    // -----------------------------------------------------------------------
    always @(negedge clk_i) begin : monitor
        entry_t e;
        #1;
        if (rst_ni && mem_req_o && mem_gnt_i) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_unexpected: got a request with addr %h, expected none at %0t",
                         mem_addr_o, $time);
            end else begin
                e = q.pop_front();
                check("mem_addr", {32'd0, mem_addr_o}, {32'd0, e.addr});
                check("mem_data", mem_data_o, e.data);
                check("mem_be", {56'd0, mem_be_o}, {56'd0, e.be});
                check("mem_tid", {62'd0, mem_tid_o}, 64'(m_tid));
                m_tid = (m_tid + 1) % 4;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk_i);
        #2;
        case (ack_mode)
            0:       mem_ack_i = 1'b0;
            1:       mem_ack_i = (m_out > 0);
            default: mem_ack_i = (m_out > 0) && ($urandom_range(0, 1) == 1);
        endcase
    endtask

    task automatic sample();
        @(negedge clk_i);
        #2;
    endtask

    task automatic idle();
        st_valid_i = 1'b0;
        st_addr_i  = '0;
        st_data_i  = '0;
        st_be_i    = 8'h01;
        st_nc_i    = 1'b0;
        mem_gnt_i  = 1'b0;
        mem_ack_i  = 1'b0;
        rd_addr_i  = '0;
        ack_mode   = 0;
    endtask

    task automatic do_reset(input int n);
        rst_ni = 1'b0;
        repeat (n) next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic send_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be,
                              input logic nc, input int max_cyc, input bit must,
                              output bit acc);
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_data_i  = d;
        st_be_i    = be;
        st_nc_i    = nc;
        acc        = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            sample();
            acc = st_ready_o;
            next_cycle();
            if (acc) break;
        end
        st_valid_i = 1'b0;
        st_nc_i    = 1'b0;
        if (must && !acc) begin
            checks++;
            errors++;
            $display("FAIL store_timeout: addr %h not accepted within %0d cycles", a, max_cyc);
        end
    endtask

    task automatic drain();
        bit done;
        mem_gnt_i = 1'b1;
        ack_mode  = 1;
        done      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((q.size() == 0) && (m_out == 0)) begin
                done = 1'b1;
                break;
            end
            next_cycle();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries and %0d writes left, expected none",
                     q.size(), m_out);
        end
        mem_gnt_i = 1'b0;
        ack_mode  = 0;
        next_cycle();
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin : stim
        bit          acc;
        logic [31:0] pool [4];
        pool[0] = 32'h0000_0100;
        pool[1] = 32'h0000_0208;
        pool[2] = 32'h0000_0300;
        pool[3] = 32'h8000_0010;

        idle();
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_valid_i = 1'($urandom_range(0, 1));
            st_addr_i  = $urandom;
            st_data_i  = {$urandom, $urandom};
            st_be_i    = 8'($urandom);
            st_nc_i    = 1'($urandom_range(0, 1));
            mem_gnt_i  = 1'($urandom_range(0, 1));
            mem_ack_i  = 1'($urandom_range(0, 1));
            rd_addr_i  = $urandom;
            @(posedge clk_i);
            #2;
        end
        idle();
        rst_ni = 1'b1;
        next_cycle();
        next_cycle();

        // Single store, granted on its first request cycle
        mem_gnt_i = 1'b1;
        send_store(32'h8000_0014, 64'hAABBCCDD_00000000, 8'hF0, 1'b0, 4, 1'b1, acc);
        sample();
        check("single_req", {63'd0, mem_req_o}, 64'd1);
        check("single_addr", {32'd0, mem_addr_o}, 64'h8000_0010);
        check("single_tid", {62'd0, mem_tid_o}, 64'd0);
        next_cycle();
        mem_gnt_i = 1'b0;
        sample();
        check("single_outstanding", {61'd0, outstanding_o}, 64'd1);
        check("single_not_empty", {63'd0, empty_o}, 64'd0);
        ack_mode = 1;
        next_cycle();
        ack_mode = 0;
        next_cycle();
        sample();
        check("single_acked_empty", {63'd0, empty_o}, 64'd1);
        next_cycle();

        // Same-word stores with the port stalled
        mem_gnt_i = 1'b0;
        send_store(32'h0000_0100, {$urandom, $urandom}, 8'h0F, 1'b0, 4, 1'b1, acc);
        send_store(32'h0000_0208, {$urandom, $urandom}, 8'h0F, 1'b0, 4, 1'b1, acc);
        send_store(32'h0000_020C, {$urandom, $urandom}, 8'hF0, 1'b0, 3, 1'b0, acc);
`ifdef STORE_BUF_MERGE_EN
        check("merge_accepted", {63'd0, acc}, 64'd1);
`else
        check("nomerge_stall", {63'd0, acc}, 64'd0);
`endif
        mem_gnt_i = 1'b1;
        if (!acc) send_store(32'h0000_020C, st_data_i, 8'hF0, 1'b0, 10, 1'b1, acc);
        drain();

        // Non-cacheable stores to one word stay separate and are hazard-visible
        rd_addr_i = 32'h0000_0304;
        send_store(32'h0000_0300, {$urandom, $urandom}, 8'h0F, 1'b1, 4, 1'b1, acc);
        send_store(32'h0000_0300, {$urandom, $urandom}, 8'h3C, 1'b1, 4, 1'b1, acc);
        sample();
        check("nc_hit", {63'd0, rd_hit_o}, 64'd1);
        next_cycle();
        drain();
        rd_addr_i = '0;

        // Outstanding limit
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_store(32'h0000_1000 + 32'(8 * i), {$urandom, $urandom}, 8'hFF, 1'b0, 4, 1'b1,
                       acc);
        end
        next_cycle();
        sample();
        check("limit_outstanding", {61'd0, outstanding_o}, 64'd7);
        check("limit_req_low", {63'd0, mem_req_o}, 64'd0);
        ack_mode = 1;
        next_cycle();
        ack_mode = 0;
        next_cycle();
        sample();
        check("limit_req_again", {63'd0, mem_req_o}, 64'd1);
        ack_mode = 1;
        repeat (4) next_cycle();
        drain();

        // TID wrap, then reset in the middle of a sequence
        do_reset(2);
        mem_gnt_i = 1'b1;
        ack_mode  = 1;
        for (int i = 0; i < 5; i++) begin
            send_store(32'h0000_2000 + 32'(8 * i), {$urandom, $urandom}, 8'h81, 1'b0, 4, 1'b1,
                       acc);
        end
        send_store(32'h0000_3000, {$urandom, $urandom}, 8'h01, 1'b0, 4, 1'b1, acc);
        send_store(32'h0000_3008, {$urandom, $urandom}, 8'h02, 1'b0, 4, 1'b1, acc);
        do_reset(2);
        mem_gnt_i = 1'b1;
        send_store(32'h0000_3010, {$urandom, $urandom}, 8'h04, 1'b0, 4, 1'b1, acc);
        sample();
        check("post_reset_tid", {62'd0, mem_tid_o}, 64'd0);
        next_cycle();
        drain();

        // Randomized traffic
        ack_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            st_valid_i = 1'($urandom_range(0, 1));
            st_addr_i  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 7));
            st_data_i  = {$urandom, $urandom};
            st_be_i    = 8'($urandom_range(1, 255));
            st_nc_i    = ($urandom_range(0, 3) == 0);
            mem_gnt_i  = 1'($urandom_range(0, 1));
            rd_addr_i  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                st_valid_i = 1'b0;
                do_reset(2);
                ack_mode = 2;
            end else begin
                next_cycle();
            end
        end
        st_valid_i = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
